// File: rtl/pll_clk_supervisor.sv
// PLL lock supervisor: synchronises/filters lock, sequences a held system reset and
// generates phase-aligned clock-enable strobes. Optional macro CLK_SUP_LOSS_CNT_EN adds loss_count.
module pll_clk_supervisor #(
    parameter int                   NUM_CE      = 2,
    parameter logic [16*NUM_CE-1:0] CE_DIV      = {16'd9, 16'd45},
    parameter int                   RST_HOLD    = 1024,
    parameter int                   LOCK_FILT   = 8,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lock,
    output logic              sys_rst,
    output logic              ready,
    output logic [NUM_CE-1:0] ce,
    output logic [1:0]        state
`ifdef CLK_SUP_LOSS_CNT_EN
    ,
    output logic [7:0]        loss_count
`endif
);

    localparam int MAXC = (RST_HOLD > LOCK_FILT) ? RST_HOLD : LOCK_FILT;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2,
        ST_LOST      = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_sys_rst;
    logic                   r_ready;
    logic [CW-1:0]          r_hold_cnt;
    logic [CW-1:0]          r_filt_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    logic                   w_loss;
    logic                   w_run_stay;
    logic [NUM_CE-1:0]      w_ce;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], lock};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // The loss fires on the edge that samples the LOCK_FILT-th consecutive low.
    assign w_loss     = (r_state == ST_RUN) && !w_lock_s && (r_filt_cnt == FILT_LAST);
    assign w_run_stay = (r_state == ST_RUN) && !w_loss;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_WAIT_LOCK;
            r_sys_rst  <= 1'b1;
            r_ready    <= 1'b0;
            r_hold_cnt <= '0;
            r_filt_cnt <= '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    r_sys_rst  <= 1'b1;
                    r_ready    <= 1'b0;
                    r_hold_cnt <= '0;
                    r_filt_cnt <= '0;
                    if (w_lock_s) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!w_lock_s) begin
                        r_state    <= ST_WAIT_LOCK;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state    <= ST_RUN;
                        r_sys_rst  <= 1'b0;
                        r_ready    <= 1'b1;
                        r_hold_cnt <= '0;
                        r_filt_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_loss) begin
                        r_state    <= ST_LOST;
                        r_sys_rst  <= 1'b1;
                        r_ready    <= 1'b0;
                        r_filt_cnt <= '0;
                    end else if (!w_lock_s) begin
                        r_filt_cnt <= r_filt_cnt + 1'b1;
                    end else begin
                        r_filt_cnt <= '0;
                    end
                end
                ST_LOST: begin
                    r_state   <= ST_WAIT_LOCK;
                    r_sys_rst <= 1'b1;
                    r_ready   <= 1'b0;
                end
                default: begin
                    r_state <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

`ifdef CLK_SUP_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_loss_cnt <= '0;
        end else if (w_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign loss_count = r_loss_cnt;
`endif

    // Dividers idle at 0 outside RUN so every channel starts in phase at RUN entry.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CE; gi++) begin : g_ce
            localparam logic [15:0] DIV = CE_DIV[16*gi +: 16];
            if (DIV == 16'd0) begin : g_off
                assign w_ce[gi] = 1'b0;
            end else begin : g_on
                logic [15:0] r_div_cnt;
                logic        r_ce;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_div_cnt <= '0;
                        r_ce      <= 1'b0;
                    end else if (w_run_stay) begin
                        if (r_div_cnt == DIV - 16'd1) begin
                            r_div_cnt <= '0;
                            r_ce      <= 1'b1;
                        end else begin
                            r_div_cnt <= r_div_cnt + 16'd1;
                            r_ce      <= 1'b0;
                        end
                    end else begin
                        r_div_cnt <= '0;
                        r_ce      <= 1'b0;
                    end
                end

                assign w_ce[gi] = r_ce;
            end
        end
    endgenerate

    assign sys_rst = r_sys_rst;
    assign ready   = r_ready;
    assign ce      = w_ce;
    assign state   = r_state;

endmodule

// File: tb/tb_pll_clk_supervisor.sv
// Directed self-checking bench for pll_clk_supervisor: default instance plus a short-hold
// instance exercising DIV=1 / DIV=0 channels and loss-count saturation.
module tb_pll_clk_supervisor;

    logic       clk = 1'b0;
    logic       reset, lock, reset2, lock2;
    logic       sys_rst, ready, sys_rst2, ready2;
    logic [1:0] ce, ce2, state, state2;
`ifdef CLK_SUP_LOSS_CNT_EN
    logic [7:0] loss_count, loss_count2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_clk_supervisor #(
        .NUM_CE(2), .CE_DIV({16'd9, 16'd45}), .RST_HOLD(1024), .LOCK_FILT(8), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .lock(lock), .sys_rst(sys_rst), .ready(ready),
        .ce(ce), .state(state)
`ifdef CLK_SUP_LOSS_CNT_EN
        , .loss_count(loss_count)
`endif
    );

    pll_clk_supervisor #(
        .NUM_CE(2), .CE_DIV({16'd0, 16'd1}), .RST_HOLD(4), .LOCK_FILT(2), .SYNC_STAGES(2)
    ) dut2 (
        .clk(clk), .reset(reset2), .lock(lock2), .sys_rst(sys_rst2), .ready(ready2),
        .ce(ce2), .state(state2)
`ifdef CLK_SUP_LOSS_CNT_EN
        , .loss_count(loss_count2)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts edges from the current point until sys_rst releases; flags illegal outputs on the way.
    task automatic measure_release(output int n_rel, output int n_hold, output int bad);
        n_rel = 0; n_hold = 0; bad = 0;
        for (int n = 1; n <= 1100 && n_rel == 0; n++) begin
            tick(1);
            if (state === 2'd1 && n_hold == 0) n_hold = n;
            if (sys_rst === 1'b0) begin
                n_rel = n;
            end else begin
                if (ready !== 1'b0 || ce !== 2'b00) bad++;
                if (n_hold == 0 && state !== 2'd0) bad++;
                if (n_hold != 0 && state !== 2'd1) bad++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; lock = 1'b0; reset2 = 1'b1; lock2 = 1'b0;
        tick(5);
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (ce !== 2'b00) begin errors++; $display("FAIL reset_ce: got %b expected 00", ce); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
`ifdef CLK_SUP_LOSS_CNT_EN
        checks++; if (loss_count !== 8'd0) begin errors++; $display("FAIL reset_loss_count: got %0d expected 0", loss_count); end
`endif
        reset = 1'b0;
        $display("test_reset: outputs checked after 5 reset cycles");
    endtask

    task automatic test_power_up();
        int n_rel, n_hold, bad;
        tick(20);
        lock = 1'b1;
        measure_release(n_rel, n_hold, bad);
        checks++; if (n_rel < 1026 || n_rel > 1028) begin errors++; $display("FAIL powerup_release_edge: got %0d expected 1027 +-1", n_rel); end
        checks++; if (n_hold < 2 || n_hold > 4) begin errors++; $display("FAIL powerup_hold_entry: got %0d expected 3 +-1", n_hold); end
        checks++; if (bad != 0) begin errors++; $display("FAIL powerup_sequence: got %0d bad samples expected 0", bad); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL powerup_ready: got %b expected 1", ready); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL powerup_state: got %0d expected 2", state); end
        checks++; if (ce !== 2'b00) begin errors++; $display("FAIL powerup_ce_entry: got %b expected 00", ce); end
        $display("test_power_up: sys_rst released %0d edges after lock, hold entered at %0d", n_rel, n_hold);
    endtask

    task automatic test_ce_count();
        int c0 = 0, c1 = 0, f0 = 0, f1 = 0;
        for (int k = 1; k <= 900; k++) begin
            tick(1);
            if (ce[0] === 1'b1) begin c0++; if (f0 == 0) f0 = k; end
            if (ce[1] === 1'b1) begin c1++; if (f1 == 0) f1 = k; end
        end
        checks++; if (c0 != 20) begin errors++; $display("FAIL ce0_count: got %0d expected 20", c0); end
        checks++; if (c1 != 100) begin errors++; $display("FAIL ce1_count: got %0d expected 100", c1); end
        checks++; if (f0 != 45) begin errors++; $display("FAIL ce0_first: got %0d expected 45", f0); end
        checks++; if (f1 != 9) begin errors++; $display("FAIL ce1_first: got %0d expected 9", f1); end
        $display("test_ce_count: ce0=%0d ce1=%0d first at %0d/%0d", c0, c1, f0, f1);
    endtask

    task automatic test_glitch_filter();
        int bs = 0, bc = 0;
        logic e0, e1;
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            e0 = (k % 45 == 0);
            e1 = (k % 9 == 0);
            if (state !== 2'd2) bs++;
            if (ce[0] !== e0 || ce[1] !== e1) bc++;
            if (k == 3) lock = 1'b0;
            if (k == 10) lock = 1'b1;
        end
        checks++; if (bs != 0) begin errors++; $display("FAIL glitch_state: got %0d non-RUN samples expected 0", bs); end
        checks++; if (bc != 0) begin errors++; $display("FAIL glitch_ce: got %0d ce deviations expected 0", bc); end
        $display("test_glitch_filter: 7-cycle low ignored");
    endtask

    task automatic test_lock_loss();
        int n_lost = 0, bs = 0;
        lock = 1'b0;
        for (int n = 1; n <= 30 && n_lost == 0; n++) begin
            tick(1);
            if (state === 2'd3) n_lost = n;
            else if (state !== 2'd2) bs++;
        end
        checks++; if (n_lost < 9 || n_lost > 11) begin errors++; $display("FAIL loss_edge: got %0d expected 10 +-1", n_lost); end
        checks++; if (bs != 0) begin errors++; $display("FAIL loss_pre_state: got %0d bad samples expected 0", bs); end
        checks++; if (sys_rst !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL loss_outputs: got sys_rst=%b ready=%b expected 1/0", sys_rst, ready); end
        checks++; if (ce !== 2'b00) begin errors++; $display("FAIL loss_ce: got %b expected 00", ce); end
        tick(1);
        checks++; if (state !== 2'd0 || sys_rst !== 1'b1) begin errors++; $display("FAIL loss_next: got state=%0d sys_rst=%b expected 0/1", state, sys_rst); end
`ifdef CLK_SUP_LOSS_CNT_EN
        checks++; if (loss_count !== 8'd1) begin errors++; $display("FAIL loss_count_one: got %0d expected 1", loss_count); end
`endif
        $display("test_lock_loss: LOST reached %0d edges after lock fall", n_lost);
    endtask

    task automatic test_hold_abort();
        int n_h = 0, n_w = 0, n_rel, n_hold, bad, rst_bad = 0;
        lock = 1'b1;
        for (int n = 1; n <= 10 && n_h == 0; n++) begin
            tick(1);
            if (state === 2'd1) n_h = n;
        end
        tick(500);
        checks++; if (n_h == 0 || state !== 2'd1 || sys_rst !== 1'b1) begin errors++; $display("FAIL abort_in_hold: got state=%0d sys_rst=%b expected 1/1", state, sys_rst); end
        lock = 1'b0;
        for (int n = 1; n <= 10 && n_w == 0; n++) begin
            tick(1);
            if (sys_rst !== 1'b1) rst_bad++;
            if (state === 2'd0) n_w = n;
        end
        tick(5);
        checks++; if (n_w == 0 || state !== 2'd0) begin errors++; $display("FAIL abort_to_wait: got state=%0d expected 0", state); end
        checks++; if (rst_bad != 0 || sys_rst !== 1'b1) begin errors++; $display("FAIL abort_sys_rst: got %0d release samples expected 0", rst_bad); end
        lock = 1'b1;
        measure_release(n_rel, n_hold, bad);
        checks++; if (n_rel < 1026 || n_rel > 1028) begin errors++; $display("FAIL abort_restart_edge: got %0d expected 1027 +-1", n_rel); end
        checks++; if (bad != 0 || ready !== 1'b1) begin errors++; $display("FAIL abort_restart_seq: got bad=%0d ready=%b expected 0/1", bad, ready); end
        $display("test_hold_abort: restart released after %0d edges", n_rel);
    endtask

    task automatic test_async_reset();
        int seen = 0;
        for (int n = 1; n <= 20 && seen == 0; n++) begin
            tick(1);
            if (ce[1] === 1'b1) seen = n;
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL async_ce_wait: got no ce[1] pulse expected one within 20"); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL async_sys_rst: got %b expected 1", sys_rst); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", ready); end
        checks++; if (ce !== 2'b00) begin errors++; $display("FAIL async_ce: got %b expected 00", ce); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", state); end
`ifdef CLK_SUP_LOSS_CNT_EN
        checks++; if (loss_count !== 8'd0) begin errors++; $display("FAIL async_loss_count: got %0d expected 0", loss_count); end
`endif
        lock = 1'b0;
        tick(3);
        reset = 1'b0;
        $display("test_async_reset: outputs cleared between edges");
    endtask

    task automatic test_ce_div_edges();
        int n_rdy = 0, b0 = 0, b1 = 0;
        reset2 = 1'b0;
        tick(1);
        lock2 = 1'b1;
        for (int n = 1; n <= 30 && n_rdy == 0; n++) begin
            tick(1);
            if (ready2 === 1'b1) n_rdy = n;
        end
        checks++; if (n_rdy < 6 || n_rdy > 8) begin errors++; $display("FAIL div_hold_edge: got %0d expected 7 +-1", n_rdy); end
        checks++; if (sys_rst2 !== 1'b0) begin errors++; $display("FAIL div_sys_rst: got %b expected 0", sys_rst2); end
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (ce2[0] !== 1'b1) b0++;
            if (ce2[1] !== 1'b0) b1++;
        end
        checks++; if (b0 != 0) begin errors++; $display("FAIL div1_const_high: got %0d low samples expected 0", b0); end
        checks++; if (b1 != 0) begin errors++; $display("FAIL div0_const_low: got %0d high samples expected 0", b1); end
        $display("test_ce_div_edges: DIV=1 and DIV=0 channels checked");
    endtask

`ifdef CLK_SUP_LOSS_CNT_EN
    task automatic test_loss_saturation();
        int to = 0;
        logic [7:0] at255 = 8'd0;
        for (int i = 1; i <= 300; i++) begin
            int got = 0;
            lock2 = 1'b0;
            for (int n = 1; n <= 20 && got == 0; n++) begin
                tick(1);
                if (state2 === 2'd3) got = 1;
            end
            if (got == 0) to++;
            lock2 = 1'b1;
            got = 0;
            for (int n = 1; n <= 30 && got == 0; n++) begin
                tick(1);
                if (ready2 === 1'b1) got = 1;
            end
            if (got == 0) to++;
            if (i == 255) at255 = loss_count2;
        end
        checks++; if (to != 0) begin errors++; $display("FAIL sat_timeouts: got %0d expected 0", to); end
        checks++; if (at255 !== 8'd255) begin errors++; $display("FAIL sat_at_255: got %0d expected 255", at255); end
        checks++; if (loss_count2 !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", loss_count2); end
        $display("test_loss_saturation: loss_count=%0d after 300 events", loss_count2);
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_ce_count();
        test_glitch_filter();
        test_lock_loss();
        test_hold_abort();
        test_async_reset();
        test_ce_div_edges();
`ifdef CLK_SUP_LOSS_CNT_EN
        test_loss_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
